// File: rtl/interleave_ram_ctrl.sv
// Interleaver RAM sequencer: permuted bit-serial writes into two ping-pong banks of
// subcarrier words, and one-word-per-handshake reads of a completed bank to the mapper.
module interleave_ram_ctrl #(
  parameter int unsigned N_SC = 48
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mod_i,
  input  logic       flush_i,
  input  logic       in_valid,
  input  logic       in_bit,
  output logic       in_ready,
  output logic [9:0] ram_waddr,
  output logic       ram_wen,
  output logic       ram_wdata,
  output logic [6:0] ram_raddr,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic [1:0] out_mod
);
  localparam int unsigned KW = 9;
  localparam int unsigned RW = 6;

  logic [1:0]      full;
  logic [1:0][1:0] bank_mod;
  logic            wb;
  logic            rb;
  logic [KW-1:0]   k;
  logic [RW-1:0]   r;

  logic [1:0]    mod_cur;
  logic [KW-1:0] cbps;
  logic [4:0]    cbps16;
  logic [KW-1:0] i;
  logic [KW-1:0] i3;
  logic [KW-1:0] i12;
  logic [KW-1:0] i18;
  logic [1:0]    rr64;
  logic          b16;
  logic [KW-1:0] j16;
  logic [5:0]    sc;
  logic [2:0]    bp;
  logic          accept;
  logic          last_bit;
  logic          rd;

  // The first bit of a symbol sees mod_i before it is latched into the bank
  assign mod_cur = (k == '0) ? mod_i : bank_mod[wb];

  always_comb begin
    cbps   = KW'(48);
    cbps16 = 5'd3;
    case (mod_cur)
      2'd1: begin cbps = KW'(96);  cbps16 = 5'd6;  end
      2'd2: begin cbps = KW'(192); cbps16 = 5'd12; end
      2'd3: begin cbps = KW'(288); cbps16 = 5'd18; end
      default: ;
    endcase
  end

  // First permutation, then the floor(16i/N_CBPS) term is i / (N_CBPS/16)
  assign i    = KW'(cbps16) * KW'(k[3:0]) + KW'(k[8:4]);
  assign i3   = i / KW'(3);
  assign i12  = i / KW'(12);
  assign i18  = i / KW'(18);
  assign rr64 = 2'((i - i18) % KW'(3));
  assign b16  = 1'(i - i12);
  assign j16  = {i[8:1], b16};

  // Split j into subcarrier and bit position; for 64QAM j/6 == (i/3)/2
  always_comb begin
    sc = 6'(i);
    bp = 3'd0;
    case (mod_cur)
      2'd1: begin sc = 6'(i >> 1);   bp = {2'b00, i[0]}; end
      2'd2: begin sc = 6'(j16 >> 2); bp = {1'b0, j16[1:0]}; end
      2'd3: begin
        sc = 6'(i3 >> 1);
        bp = i3[0] ? 3'd3 + 3'(rr64) : 3'(rr64);
      end
      default: ;
    endcase
  end

  assign in_ready  = !full[wb] && !rst && !flush_i;
  assign accept    = in_valid && in_ready;
  assign ram_wen   = accept;
  assign ram_wdata = in_bit;
  assign ram_waddr = {wb, sc, bp};
  assign last_bit  = (k == cbps - KW'(1));

  assign out_valid = full[rb];
  assign ram_raddr = {rb, r};
  assign out_last  = (r == RW'(N_SC - 1));
  assign out_mod   = bank_mod[rb];
  assign rd        = out_valid && out_ready;

  // Write and read completions always hit different banks, so both may land together
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      full     <= '0;
      bank_mod <= '0;
      wb       <= 1'b0;
      rb       <= 1'b0;
      k        <= '0;
      r        <= '0;
    end else begin
      if (accept) begin
        if (k == '0) bank_mod[wb] <= mod_i;
        if (last_bit) begin
          k        <= '0;
          full[wb] <= 1'b1;
          wb       <= ~wb;
        end else begin
          k <= k + KW'(1);
        end
      end
      if (rd) begin
        if (out_last) begin
          r        <= '0;
          full[rb] <= 1'b0;
          rb       <= ~rb;
        end else begin
          r <= r + RW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_interleave_ram_ctrl.sv
// Directed bench for interleave_ram_ctrl: bit-addressed RAM model plus a reference
// 802.11a/g interleaver used to predict write addresses and read words.
module tb_interleave_ram_ctrl;
  localparam int N_SC = 48;

  logic       clk;
  logic       rst;
  logic [1:0] mod_i;
  logic       flush_i;
  logic       in_valid;
  logic       in_bit;
  logic       in_ready;
  logic [9:0] ram_waddr;
  logic       ram_wen;
  logic       ram_wdata;
  logic [6:0] ram_raddr;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic [1:0] out_mod;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  logic [7:0] mem [128];
  logic [5:0] exp_word [2][64];
  logic [9:0] last_wa [288];

  interleave_ram_ctrl #(.N_SC(N_SC)) dut (
    .clk(clk), .rst(rst), .mod_i(mod_i), .flush_i(flush_i),
    .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready),
    .ram_waddr(ram_waddr), .ram_wen(ram_wen), .ram_wdata(ram_wdata),
    .ram_raddr(ram_raddr), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .out_mod(out_mod)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bit-write RAM with a combinational word read
  always @(posedge clk) if (ram_wen) mem[ram_waddr[9:3]][ram_waddr[2:0]] <= ram_wdata;

  function automatic int nbpsc(input logic [1:0] m);
    case (m)
      2'd0: return 1;
      2'd1: return 2;
      2'd2: return 4;
      default: return 6;
    endcase
  endfunction

  // Reference interleaver written directly from the standard's two permutations
  function automatic logic [8:0] model_sb(input logic [1:0] m, input int k);
    int nb, ncbps, s, i, j;
    nb    = nbpsc(m);
    ncbps = 48 * nb;
    s     = (nb / 2 > 1) ? nb / 2 : 1;
    i     = (ncbps / 16) * (k % 16) + k / 16;
    j     = s * (i / s) + (i + ncbps - (16 * i) / ncbps) % s;
    return {6'(j / nb), 3'(j % nb)};
  endfunction

  task automatic do_reset();
    rst = 1'b1; flush_i = 1'b0; in_valid = 1'b0; out_ready = 1'b0; mod_i = 2'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic put_bit(input logic b, input logic [1:0] m, output logic [9:0] wa,
                         output logic [1:0] wf, output logic ok);
    in_valid = 1'b1; in_bit = b; mod_i = m;
    ok = 1'b0; wa = '0; wf = '0;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (in_ready) begin
        wa = ram_waddr; wf = {ram_wen, ram_wdata}; ok = 1'b1;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic send_bits(input logic [1:0] m, input logic bank, input int k0,
                           input int n, input bit scramble);
    logic [9:0] wa;
    logic [1:0] wf;
    logic       ok;
    logic       b;
    logic [1:0] mi;
    logic [8:0] sb;
    for (int k = k0; k < k0 + n; k++) begin
      b  = 1'($urandom_range(0, 1));
      mi = (k == 0 || !scramble) ? m : 2'($urandom_range(0, 3));
      put_bit(b, mi, wa, wf, ok);
      sb = model_sb(m, k);
      exp_word[bank][sb[8:3]][sb[2:0]] = b;
      last_wa[k] = wa;
      vectors++;
      if (!ok || wa !== {bank, sb} || wf !== {1'b1, b}) begin
        errors++;
        $display("FAIL write k=%0d mod=%0d: ok=%0b waddr=%0d wen/wdata=%b want waddr=%0d wdata=%b",
                 k, m, ok, wa, wf, {bank, sb}, b);
      end
    end
  endtask

  task automatic read_words(input logic bank, input logic [1:0] m, input int r0,
                            input int n, input bit stall);
    logic [5:0] mask;
    logic       ok;
    mask = 6'((1 << nbpsc(m)) - 1);
    for (int r = r0; r < r0 + n; r++) begin
      ok = 1'b0;
      for (int t = 0; t < 300; t++) begin
        out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
        if (out_valid) begin
          vectors++;
          if (ram_raddr !== {bank, 6'(r)} || out_last !== (r == N_SC - 1) || out_mod !== m ||
              (mem[ram_raddr][5:0] & mask) !== (exp_word[bank][r] & mask)) begin
            errors++;
            $display("FAIL read bank=%0d r=%0d: raddr=%0d last=%b mod=%0d data=%b want raddr=%0d last=%b mod=%0d data=%b",
                     bank, r, ram_raddr, out_last, out_mod, mem[ram_raddr][5:0] & mask,
                     {bank, 6'(r)}, (r == N_SC - 1), m, exp_word[bank][r] & mask);
          end
          if (out_ready) begin
            ok = 1'b1;
            @(posedge clk); #1;
            break;
          end
        end
        @(posedge clk); #1;
      end
      if (!ok) begin
        vectors++; errors++;
        $display("FAIL read_timeout bank=%0d r=%0d: out_valid=%b want 1", bank, r, out_valid);
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_bit = 1'b1; out_ready = 1'b1; mod_i = 2'd3;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b0 || ram_wen !== 1'b0 || out_valid !== 1'b0 || ram_waddr !== 10'd0 ||
        ram_raddr !== 7'd0 || out_last !== 1'b0 || out_mod !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b wen=%b ov=%b wa=%0d ra=%0d last=%b mod=%0d want 0s",
               in_ready, ram_wen, out_valid, ram_waddr, ram_raddr, out_last, out_mod);
    end
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1 || ram_wen !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: rdy=%b wen=%b ov=%b want 1 0 0", in_ready, ram_wen, out_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_bpsk();
    do_reset();
    send_bits(2'd0, 1'b0, 0, 47, 0);
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL bpsk_partial: out_valid=%b want 0", out_valid);
    end
    @(posedge clk); #1;
    send_bits(2'd0, 1'b0, 47, 1, 0);
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b1 || ram_raddr !== 7'd0 || out_mod !== 2'd0) begin
      errors++;
      $display("FAIL bpsk_latency: ov=%b ra=%0d mod=%0d want 1 0 0", out_valid, ram_raddr, out_mod);
    end
    vectors++;
    if (last_wa[0] !== 10'd0 || last_wa[1] !== 10'd24 || last_wa[16] !== 10'd8) begin
      errors++;
      $display("FAIL bpsk_addr: k0=%0d k1=%0d k16=%0d want 0 24 8", last_wa[0], last_wa[1], last_wa[16]);
    end
    @(posedge clk); #1;
    read_words(1'b0, 2'd0, 0, N_SC, 0);
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL bpsk_empty: out_valid=%b want 0", out_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_qam();
    do_reset();
    send_bits(2'd3, 1'b0, 0, 288, 0);
    vectors++;
    if (last_wa[0] !== 10'd0 || last_wa[1] !== 10'd26) begin
      errors++;
      $display("FAIL qam64_addr: k0=%0d k1=%0d want 0 26", last_wa[0], last_wa[1]);
    end
    send_bits(2'd2, 1'b1, 0, 192, 0);
    vectors++;
    if (last_wa[17] !== 10'd536) begin
      errors++; $display("FAIL qam16_addr: k17=%0d want 536", last_wa[17]);
    end
    read_words(1'b0, 2'd3, 0, N_SC, 0);
    read_words(1'b1, 2'd2, 0, N_SC, 0);
  endtask

  task automatic test_back_to_back();
    int c0;
    do_reset();
    send_bits(2'd1, 1'b0, 0, 96, 0);
    send_bits(2'd1, 1'b1, 0, 96, 0);
    in_valid = 1'b1; in_bit = 1'b1; mod_i = 2'd1;
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if (in_ready !== 1'b0 || ram_wen !== 1'b0) begin
        errors++; $display("FAIL b2b_full: rdy=%b wen=%b want 0 0", in_ready, ram_wen);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    c0 = cyc;
    read_words(1'b0, 2'd1, 0, N_SC, 0);
    vectors++;
    if (cyc - c0 !== N_SC) begin
      errors++; $display("FAIL b2b_drain_cycles: got %0d want %0d", cyc - c0, N_SC);
    end
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1 || ram_waddr[9] !== 1'b0) begin
      errors++; $display("FAIL b2b_free: rdy=%b wa9=%b want 1 0", in_ready, ram_waddr[9]);
    end
    @(posedge clk); #1;
    send_bits(2'd1, 1'b0, 0, 96, 0);
    read_words(1'b1, 2'd1, 0, N_SC, 0);
    read_words(1'b0, 2'd1, 0, N_SC, 0);
  endtask

  task automatic test_simultaneous();
    logic       b;
    logic [8:0] sb;
    do_reset();
    send_bits(2'd0, 1'b0, 0, 48, 0);
    send_bits(2'd1, 1'b1, 0, 95, 0);
    read_words(1'b0, 2'd0, 0, N_SC - 1, 0);
    b  = 1'($urandom_range(0, 1));
    sb = model_sb(2'd1, 95);
    exp_word[1][sb[8:3]][sb[2:0]] = b;
    in_valid = 1'b1; in_bit = b; mod_i = 2'd1; out_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1 || ram_wen !== 1'b1 || ram_waddr !== {1'b1, sb} ||
        out_valid !== 1'b1 || out_last !== 1'b1 || ram_raddr !== 7'd47) begin
      errors++;
      $display("FAIL simul_cycle: rdy=%b wen=%b wa=%0d ov=%b last=%b ra=%0d want 1 1 %0d 1 1 47",
               in_ready, ram_wen, ram_waddr, out_valid, out_last, ram_raddr, {1'b1, sb});
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b1 || ram_raddr !== 7'd64 || out_mod !== 2'd1 ||
        in_ready !== 1'b1 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL simul_after: ov=%b ra=%0d mod=%0d rdy=%b last=%b want 1 64 1 1 0",
               out_valid, ram_raddr, out_mod, in_ready, out_last);
    end
    @(posedge clk); #1;
    read_words(1'b1, 2'd1, 0, N_SC, 0);
  endtask

  task automatic test_backpressure();
    do_reset();
    send_bits(2'd2, 1'b0, 0, 192, 1);
    send_bits(2'd3, 1'b1, 0, 288, 1);
    read_words(1'b0, 2'd2, 0, N_SC, 1);
    read_words(1'b1, 2'd3, 0, N_SC, 1);
  endtask

  task automatic test_abort(input bit use_flush);
    do_reset();
    send_bits(2'd0, 1'b0, 0, 48, 0);
    send_bits(2'd2, 1'b1, 0, 100, 0);
    read_words(1'b0, 2'd0, 0, 20, 0);
    if (use_flush) flush_i = 1'b1; else rst = 1'b1;
    in_valid = 1'b1; in_bit = 1'b1; mod_i = 2'd3; out_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b0 || ram_wen !== 1'b0) begin
      errors++; $display("FAIL abort%0d_during: rdy=%b wen=%b want 0 0", use_flush, in_ready, ram_wen);
    end
    @(posedge clk); #1;
    rst = 1'b0; flush_i = 1'b0; in_valid = 1'b0; out_ready = 1'b0; mod_i = 2'd0;
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0 || ram_waddr !== 10'd0 || in_ready !== 1'b1 || ram_raddr !== 7'd0 ||
        out_last !== 1'b0 || out_mod !== 2'd0) begin
      errors++;
      $display("FAIL abort%0d_after: ov=%b wa=%0d rdy=%b ra=%0d last=%b mod=%0d want 0 0 1 0 0 0",
               use_flush, out_valid, ram_waddr, in_ready, ram_raddr, out_last, out_mod);
    end
    @(posedge clk); #1;
    send_bits(2'd0, 1'b0, 0, 48, 0);
    read_words(1'b0, 2'd0, 0, N_SC, 0);
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL abort%0d_stale_bank: ov=%b want 0", use_flush, out_valid);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; flush_i = 1'b0; in_valid = 1'b0; in_bit = 1'b0; mod_i = 2'd0; out_ready = 1'b0;
    for (int a = 0; a < 128; a++) mem[a] = 8'h00;
    test_reset();
    test_bpsk();
    test_qam();
    test_back_to_back();
    test_simultaneous();
    test_backpressure();
    test_abort(1'b0);
    test_abort(1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
